// File: rtl/usr_pkg.sv
// Shared types and width helpers for the universal shift register.
package usr_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHL  = 3'd2,
    OP_SHR  = 3'd3,
    OP_SRA  = 3'd4,
    OP_ROL  = 3'd5,
    OP_ROR  = 3'd6,
    OP_SER  = 3'd7
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bits needed for a shift amount (and the frame counter, which peaks at N-1).
  function automatic int sh_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/usr_if.sv
// Command / data bundle between a controller and the shift register.
interface usr_if #(parameter int N = 8);
  import usr_pkg::*;
  localparam int SH_W = sh_w(N);

  logic            cmd_valid;
  logic            cmd_ready;
  op_e             cmd_op;
  logic [SH_W-1:0] cmd_amt;
  logic [N-1:0]    pin;
  logic            sin;
  logic [N-1:0]    pout;
  logic            sout;
  logic            busy;
  logic            done;

  modport master (
    output cmd_valid, cmd_op, cmd_amt, pin, sin,
    input  cmd_ready, pout, sout, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, pin, sin,
    output cmd_ready, pout, sout, busy, done
  );
endinterface

// File: rtl/usr_barrel.sv
// Combinational shifter / rotator. Amounts >= N saturate shifts to the fill
// value; rotates wrap modulo N so odd widths behave like a true ring.
module usr_barrel
  import usr_pkg::*;
#(
  parameter int N    = 8,
  parameter int SH_W = sh_w(N)
) (
  input  logic [N-1:0]    data,
  input  logic [SH_W-1:0] amt,
  input  op_e             op,
  output logic [N-1:0]    res
);
  localparam int N2 = 2 * N;

  logic [N2-1:0]   dd;
  logic [SH_W-1:0] ramt;
  logic            big;

  // Select the shift/rotate result; non-shift opcodes pass data through.
  always_comb begin
    res  = data;
    dd   = '0;
    big  = (int'(amt) >= N);
    ramt = SH_W'(int'(amt) % N);
    unique case (op)
      OP_SHL: res = big ? '0 : (data << amt);
      OP_SHR: res = big ? '0 : (data >> amt);
      OP_SRA: res = big ? {N{data[N-1]}} : N'($signed(data) >>> amt);
      OP_ROL: begin
        dd  = {data, data} << ramt;
        res = dd[N2-1:N];
      end
      OP_ROR: begin
        dd  = {data, data} >> ramt;
        res = dd[N-1:0];
      end
      default: res = data;
    endcase
  end
endmodule

// File: rtl/usr_framed.sv
// Universal shift register: single-cycle parallel ops plus an N-shift
// full-duplex serial frame reported through busy/done.
module usr_framed
  import usr_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic rst,
  usr_if.slave bus
);
  localparam int SH_W = sh_w(N);
  localparam int CW   = sh_w(N);

  state_e       st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0] sreg, sreg_n, bres, ser;
  logic         sout_q, sout_n, done_q, done_n, sbit, acc;

  usr_barrel #(.N(N), .SH_W(SH_W)) u_barrel (
    .data (sreg),
    .amt  (bus.cmd_amt),
    .op   (bus.cmd_op),
    .res  (bres)
  );

  assign bus.cmd_ready = (st == IDLE);
  assign bus.busy      = (st == SHIFT);
  assign bus.pout      = sreg;
  assign bus.sout      = sout_q;
  assign bus.done      = done_q;

  // State, counter, storage and serial output flops; reset aborts any frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= IDLE;
      cnt    <= '0;
      sreg   <= '0;
      sout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st     <= st_n;
      cnt    <= cnt_n;
      sreg   <= sreg_n;
      sout_q <= sout_n;
      done_q <= done_n;
    end
  end

  // Next-state: command decode in IDLE, one serial shift per edge in SHIFT.
  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    sreg_n = sreg;
    sout_n = sout_q;
    done_n = 1'b0;
    acc    = bus.cmd_valid && (st == IDLE);
    if (MSB_FIRST) begin
      sbit = sreg[N-1];
      ser  = {sreg[N-2:0], bus.sin};
    end else begin
      sbit = sreg[0];
      ser  = {bus.sin, sreg[N-1:1]};
    end
    unique case (st)
      IDLE: begin
        if (acc) begin
          unique case (bus.cmd_op)
            OP_HOLD: sreg_n = sreg;
            OP_LOAD: sreg_n = bus.pin;
            OP_SER: begin
              // Accept edge is shift 1 of N.
              sreg_n = ser;
              sout_n = sbit;
              cnt_n  = CW'(N - 1);
              st_n   = SHIFT;
            end
            default: sreg_n = bres;
          endcase
        end
      end
      SHIFT: begin
        sreg_n = ser;
        sout_n = sbit;
        cnt_n  = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          st_n   = IDLE;
          done_n = 1'b1;
        end
      end
      default: st_n = IDLE;
    endcase
  end
endmodule
